// File: rtl/muldiv_pkg.sv
// Shared multiply/divide definitions: op encodings, funct codes, default latencies
// and the HI/LO result layout. The stall unit and decoder import this package as well.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

endpackage

// File: rtl/muldiv_arith.sv
// Combinational 64-bit mult/div result. Signed divide works on magnitudes so the
// 0x80000000 / -1 case falls out as 0x80000000 rem 0 without a special path.
module muldiv_arith
  import muldiv_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output hilo_t       res,
  output logic        div_by_zero
);

  logic        sgn, neg_a, neg_b;
  logic [31:0] ua, ub, q, r;
  logic [63:0] mul_s, mul_u;

  always_comb begin
    sgn         = (op == MD_DIV);
    neg_a       = sgn & a[31];
    neg_b       = sgn & b[31];
    ua          = neg_a ? -a : a;
    ub          = neg_b ? -b : b;
    q           = (ub == '0) ? '0 : ua / ub;
    r           = (ub == '0) ? '0 : ua % ub;
    mul_s       = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    mul_u       = {32'b0, a} * {32'b0, b};
    div_by_zero = (op == MD_DIV || op == MD_DIVU) && (b == '0);
    res         = '0;
    case (op)
      MD_MULT:  res = hilo_t'(mul_s);
      MD_MULTU: res = hilo_t'(mul_u);
      default: begin
        res.lo = (neg_a ^ neg_b) ? -q : q;
        res.hi = neg_a ? -r : r;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle mult/div sequencer owning HI/LO. The result is computed at start,
// parked in a pending register, and committed when the latency counter expires.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  hilo_t            pending, res;
  logic             pend_dbz, dbz;

  muldiv_arith u_arith (
    .op          (md_op_e'(op)),
    .a           (src_a),
    .b           (src_b),
    .res         (res),
    .div_by_zero (dbz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      pending  <= '0;
      pend_dbz <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // start takes priority over a same-cycle mthi/mtlo
          if (start) begin
            pending  <= res;
            pend_dbz <= dbz;
            cnt      <= op[1] ? DIV_N : MULT_N;
            busy     <= 1'b1;
            state    <= S_RUN;
          end else if (hilo_we) begin
            if (hilo_sel) hi <= src_a;
            else          lo <= src_a;
          end
        end
        S_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
            if (!pend_dbz) begin
              hi <= pending.hi;
              lo <= pending.lo;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table for arithmetic/latency plus
// hand-written sequences for divide-by-zero, collisions and mid-op reset.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, hilo_we, hilo_sel;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] cur_hi, cur_lo;

  muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    int          n;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // inj: 0 none, 1 start pulse while busy, 2 hilo_we pulse while busy, 3 hilo_we with start
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int en, input int inj);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (inj == 3) begin hilo_we = 1'b1; hilo_sel = 1'b0; end
    @(negedge clk);
    start = 1'b0; hilo_we = 1'b0;
    chk({name, " hi held T+1"}, hi, cur_hi);
    chk({name, " lo held T+1"}, lo, cur_lo);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 3 && inj == 1) begin
        $display("note: %s injects start while busy (illegal stimulus)", name);
        start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd3;
      end
      if (n == 3 && inj == 2) begin
        $display("note: %s injects hilo_we while busy (illegal stimulus)", name);
        hilo_we = 1'b1; hilo_sel = 1'b1; src_a = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      start = 1'b0; hilo_we = 1'b0;
    end
    chk({name, " busy cycles"}, 32'(n), 32'(en));
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
    cur_hi = ehi; cur_lo = elo;
  endtask

  task automatic do_mt(input logic sel, input logic [31:0] v);
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = sel; src_a = v;
    @(negedge clk);
    hilo_we = 1'b0;
    if (sel) cur_hi = v; else cur_lo = v;
    chk("mt busy", {31'b0, busy}, 32'd0);
    chk("mt hi", hi, cur_hi);
    chk("mt lo", lo, cur_lo);
  endtask

  initial begin
    vecs[0] = '{"mult -2*3",      2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{"multu max*max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2] = '{"div -7/2",       2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{"divu 100/7",     2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        10};
    vecs[4] = '{"div min/-1",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
    vecs[5] = '{"div 7/-2",       2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[6] = '{"mult min*min",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};

    reset = 1'b1; start = 1'b0; hilo_we = 1'b0; hilo_sel = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0;
    cur_hi = '0; cur_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);

    do_mt(1'b1, 32'h11);
    do_mt(1'b0, 32'h22);
    do_op("divu 5/0", 2'b11, 32'd5, 32'd0, 32'h11, 32'h22, 10, 0);
    do_op("div -3/0", 2'b10, 32'hFFFF_FFFD, 32'd0, 32'h11, 32'h22, 10, 0);

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n, 0);

    // mtlo alongside start must be dropped: lo would otherwise read 2 at T+1
    do_op("start+mtlo", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 5, 3);
    do_op("start while busy", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1);
    // divide-by-zero keeps HI/LO, so a leaked mthi would be visible
    do_op("mthi while busy", 2'b11, 32'd9, 32'd0, 32'd2, 32'd14, 10, 2);

    // asynchronous reset mid-divide
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midop reset busy", {31'b0, busy}, 32'd0);
    chk("midop reset hi", hi, 32'd0);
    chk("midop reset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cur_hi = '0; cur_lo = '0;
    repeat (12) @(negedge clk);
    chk("aborted op no commit hi", hi, 32'd0);
    chk("aborted op no commit lo", lo, 32'd0);
    do_op("mult after reset", 2'b00, 32'd4, 32'd5, 32'd0, 32'd20, 5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
